// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared widths and occupancy encoding for the FIFO read streamer.
package fifo_rd_pkg;
    localparam int FIFO_WIDTH_DEF = 16;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/fifo_rd_buf2.sv
// fifo_rd_buf2: two-entry in-order buffer with registered head and occupancy.
module fifo_rd_buf2 import fifo_rd_pkg::*; #(
    parameter int W = FIFO_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output occ_t         occ,
    output logic [W-1:0] head
);
    logic [W-1:0] tail;
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= EMPTY;
            head <= '0;
            tail <= '0;
        end else if (push && pop) begin
            if (occ == TWO) begin
                head <= tail;
                tail <= din;
            end else begin
                head <= din;
            end
        end else if (push) begin
            if (occ == EMPTY) head <= din;
            else tail <= din;
            occ <= (occ == EMPTY) ? ONE : TWO;
        end else if (pop) begin
            head <= tail;
            occ  <= (occ == TWO) ? ONE : EMPTY;
        end
    end
    // The upstream request throttle guarantees a full buffer never sees a lone push.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && occ == TWO));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a registered-output FIFO read port into a valid/ready stream.
module fifo_rd_stream import fifo_rd_pkg::*; #(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      word_cnt,
    output logic                  err_underflow
);
    logic inflight;
    logic pop;
    logic push;
    occ_t occ;
    assign m_valid = occ != EMPTY;
    assign pop = m_valid && m_ready;
    assign push = inflight && !fifo_underflow;
    // Buffered plus in-flight words may not exceed the two slots, counting the slot freed this cycle.
    assign fifo_rd_en = !rst && !fifo_empty &&
                        (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            word_cnt      <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) word_cnt <= word_cnt + CNT_W'(1);
            if (inflight && fifo_underflow) err_underflow <= 1'b1;
        end
    end
    fifo_rd_buf2 #(.W(FIFO_WIDTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (fifo_dout),
        .occ  (occ),
        .head (m_data)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: random and directed stimulus against a queue-based FIFO and stream model.
module tb_fifo_rd_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [15:0] word_cnt;
    logic        err_underflow;

    fifo_rd_stream #(.FIFO_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .word_cnt       (word_cnt),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    bit [15:0] fifo_q[$];
    bit [15:0] buf_q[$];
    bit [15:0] out_log[$];
    int        pop_cyc[$];
    int        rd_cyc[$];
    bit        inflight_m = 0;
    bit        err_m = 0;
    bit [15:0] cnt_m = 0;
    int        checks = 0;
    int        errors = 0;
    int        rd_cnt = 0;
    int        cyc_n = 0;
    int        rdy_mode = 0;
    bit        uf_inj = 0;
    bit        refill = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        bit vld_m, pop_m, rd_m;
        @(negedge clk);
        vld_m = buf_q.size() > 0;
        pop_m = vld_m && m_ready;
        rd_m  = !rst && fifo_q.size() > 0 && (buf_q.size() + int'(inflight_m) < 2 + int'(pop_m));
        check("m_valid", m_valid, vld_m);
        if (vld_m) check("m_data", m_data, buf_q[0]);
        check("rd_en", fifo_rd_en, rd_m);
        check("word_cnt", word_cnt, cnt_m);
        check("err", err_underflow, err_m);
        if (fifo_rd_en) begin
            rd_cnt++;
            rd_cyc.push_back(cyc_n);
        end
        if (pop_m && !rst) begin
            out_log.push_back(buf_q[0]);
            pop_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst) begin
            buf_q.delete();
            inflight_m = 0;
            cnt_m = 0;
            err_m = 0;
        end else begin
            if (pop_m) begin
                void'(buf_q.pop_front());
                cnt_m++;
            end
            if (inflight_m && fifo_underflow) err_m = 1;
            else if (inflight_m) buf_q.push_back(fifo_dout);
            inflight_m = rd_m;
        end
        fifo_underflow = 1'b0;
        if (rd_m) begin
            fifo_dout = fifo_q.pop_front();
            fifo_underflow = uf_inj;
        end
        if (refill) while (fifo_q.size() < 4) fifo_q.push_back(16'($urandom));
        case (rdy_mode)
            0: m_ready = 1'b0;
            1: m_ready = 1'b1;
            2: m_ready = !m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = fifo_q.size() == 0;
    endtask

    task automatic wait_cnt(input bit [15:0] target);
        int n = 0;
        while (cnt_m != target && n < 70000) begin
            cyc();
            n++;
        end
        check("s6_cnt", word_cnt, target);
    endtask

    initial begin
        rst = 1'b1;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        fifo_underflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;

        // Scenario 1: five words streamed with m_ready high.
        rdy_mode = 1;
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) fifo_q.push_back(16'(i));
        fifo_empty = 1'b0;
        out_log.delete(); pop_cyc.delete(); rd_cyc.delete();
        repeat (10) cyc();
        check("s1_count", out_log.size(), 5);
        for (int i = 0; i < out_log.size(); i++) check("s1_data", out_log[i], i + 1);
        if (out_log.size() == 5 && rd_cyc.size() > 0) begin
            check("s1_latency", pop_cyc[0] - rd_cyc[0], 2);
            check("s1_back2back", pop_cyc[4] - pop_cyc[0], 4);
        end
        check("s1_word_cnt", word_cnt, 5);

        // Scenario 2: four words queued, sink stalled.
        rdy_mode = 0;
        m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(16'hA0 + 16'(i));
        fifo_empty = 1'b0;
        repeat (6) cyc();
        check("s2_rd_pulses", rd_cnt, 2);
        check("s2_head", m_data, 16'hA1);

        // Scenario 3: sink toggles ready every cycle.
        rdy_mode = 2;
        m_ready = 1'b1;
        out_log.delete();
        repeat (16) cyc();
        check("s3_count", out_log.size(), 4);
        for (int i = 0; i < out_log.size(); i++) check("s3_data", out_log[i], 16'hA1 + i);

        // Scenario 4: underflow on an in-flight read.
        rdy_mode = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 3; i++) fifo_q.push_back(16'hB0 + 16'(i));
        fifo_empty = 1'b0;
        uf_inj = 1;
        cyc();
        uf_inj = 0;
        cyc();
        check("s4_err_set", err_underflow, 1);
        repeat (4) cyc();
        check("s4_err_hold", err_underflow, 1);
        check("s4_head", m_data, 16'hB2);

        // Scenario 5: reset while streaming with a read in flight.
        rdy_mode = 1;
        refill = 1;
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("s5_valid", m_valid, 0);
        check("s5_word_cnt", word_cnt, 0);
        check("s5_err", err_underflow, 0);
        repeat (4) cyc();

        // Scenario 6: word counter wrap.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_cnt(16'hFFFE);
        wait_cnt(16'hFFFF);
        wait_cnt(16'h0000);
        wait_cnt(16'h0001);

        // Random phase.
        rdy_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            refill = $urandom_range(0, 3) != 0;
            uf_inj = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 299) == 0;
            cyc();
        end
        rst = 1'b0;
        uf_inj = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
